interp_y_pipe: RTL and testbench

- Parametrised vertical (Y) bilinear interpolation stage of the downscaling pipeline. Computes p = lerp_1·(1−w_y) + lerp_2·w_y per channel.
- Upstream: X-interpolation stage, which supplies two horizontally interpolated rows and the Y weight.
- Downstream: pixel pack/output stage.
- Scope: NCH channels sharing one weight, fixed-point format set by parameter, valid/ready backpressure, configurable pipeline depth, sideband passthrough.

---
 rtl/interp_y_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_interp_y_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_y_pipe.sv
// interp_y_pipe: vertical bilinear blend p = a*(1-w) + b*w per channel, PIPE-cycle latency.
// Define INTERP_Y_ROUND_EN for round-half-up; otherwise the sum is truncated.
module interp_y_pipe #(
    parameter int unsigned DW   = 16,
    parameter int unsigned FRAC = 8,
    parameter int unsigned NCH  = 1,
    parameter int unsigned PIPE = 2,
    parameter int unsigned UW   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [NCH*DW-1:0] i_lerp_1_q,
    input  logic [NCH*DW-1:0] i_lerp_2_q,
    input  logic [DW-1:0]     i_wy_q,
    input  logic [UW-1:0]     i_user,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NCH*DW-1:0] o_p_final_q,
    output logic [UW-1:0]     o_user,
    output logic              o_clamp
);

    localparam int unsigned WW = FRAC + 1;
    localparam int unsigned MW = DW + FRAC + 1;
    localparam int unsigned SW = DW + FRAC + 2;
    localparam int unsigned PW = NCH * DW;
    localparam logic [DW-1:0] ONE_D = DW'(1) << FRAC;
    localparam logic [WW-1:0] ONE_W = WW'(1) << FRAC;
`ifdef INTERP_Y_ROUND_EN
    localparam logic [SW-1:0] RND = SW'(1) << (FRAC - 1);
`else
    localparam logic [SW-1:0] RND = '0;
`endif

    if (PIPE == 0 || PIPE > 3) begin : g_bad_pipe
        $error("interp_y_pipe: PIPE must be in 1..3");
    end
    if (FRAC == 0 || FRAC >= DW) begin : g_bad_frac
        $error("interp_y_pipe: FRAC must be in 1..DW-1");
    end

    // Sum of the two weighted products, rounded and dropped back to DW bits.
    function automatic logic [DW-1:0] blend(input logic [MW-1:0] m1, input logic [MW-1:0] m2);
        return DW'((SW'(m1) + SW'(m2) + RND) >> FRAC);
    endfunction

    logic              w_en;
    logic              w_clamp;
    logic [WW-1:0]     w_w;
    logic [WW-1:0]     w_winv;
    logic [MW-1:0]     w_m1 [NCH];
    logic [MW-1:0]     w_m2 [NCH];
    logic [MW-1:0]     w_sm1 [NCH];
    logic [MW-1:0]     w_sm2 [NCH];
    logic              w_sv;
    logic              w_sc;
    logic [UW-1:0]     w_su;
    logic [PW-1:0]     w_res;
    logic              w_fv;
    logic              w_fc;
    logic [UW-1:0]     w_fu;
    logic [PW-1:0]     w_fp;

    logic              r_ovalid;
    logic [PW-1:0]     r_p;
    logic [UW-1:0]     r_user;
    logic              r_clamp;

    // One global enable: the whole pipe advances unless a held output is being refused.
    assign w_en    = !r_ovalid || i_ready;
    assign o_ready = w_en;

    assign w_clamp = i_wy_q > ONE_D;
    assign w_w     = w_clamp ? ONE_W : i_wy_q[WW-1:0];
    assign w_winv  = ONE_W - w_w;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_m1[k] = MW'(i_lerp_1_q[k*DW +: DW]) * MW'(w_winv);
            w_m2[k] = MW'(i_lerp_2_q[k*DW +: DW]) * MW'(w_w);
        end
    end

    if (PIPE == 1) begin : g_prod_comb
        assign w_sm1 = w_m1;
        assign w_sm2 = w_m2;
        assign w_sv  = i_valid;
        assign w_su  = i_user;
        assign w_sc  = w_clamp;
    end else begin : g_prod_reg
        logic          r_v0;
        logic [UW-1:0] r_u0;
        logic          r_c0;
        logic [MW-1:0] r_m1 [NCH];
        logic [MW-1:0] r_m2 [NCH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v0 <= 1'b0;
                r_u0 <= '0;
                r_c0 <= 1'b0;
                for (int k = 0; k < NCH; k++) begin
                    r_m1[k] <= '0;
                    r_m2[k] <= '0;
                end
            end else if (w_en) begin
                r_v0 <= i_valid;
                r_u0 <= i_user;
                r_c0 <= w_clamp;
                for (int k = 0; k < NCH; k++) begin
                    r_m1[k] <= w_m1[k];
                    r_m2[k] <= w_m2[k];
                end
            end
        end

        assign w_sm1 = r_m1;
        assign w_sm2 = r_m2;
        assign w_sv  = r_v0;
        assign w_su  = r_u0;
        assign w_sc  = r_c0;
    end

    always_comb begin
        w_res = '0;
        for (int k = 0; k < NCH; k++) begin
            w_res[k*DW +: DW] = blend(w_sm1[k], w_sm2[k]);
        end
    end

    if (PIPE == 3) begin : g_sum_reg
        logic          r_v1;
        logic [UW-1:0] r_u1;
        logic          r_c1;
        logic [PW-1:0] r_sum;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v1  <= 1'b0;
                r_u1  <= '0;
                r_c1  <= 1'b0;
                r_sum <= '0;
            end else if (w_en) begin
                r_v1  <= w_sv;
                r_u1  <= w_su;
                r_c1  <= w_sc;
                r_sum <= w_res;
            end
        end

        assign w_fv = r_v1;
        assign w_fu = r_u1;
        assign w_fc = r_c1;
        assign w_fp = r_sum;
    end else begin : g_sum_comb
        assign w_fv = w_sv;
        assign w_fu = w_su;
        assign w_fc = w_sc;
        assign w_fp = w_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovalid <= 1'b0;
            r_p      <= '0;
            r_user   <= '0;
            r_clamp  <= 1'b0;
        end else if (w_en) begin
            r_ovalid <= w_fv;
            r_p      <= w_fp;
            r_user   <= w_fu;
            r_clamp  <= w_fc;
        end
    end

    assign o_valid     = r_ovalid;
    assign o_p_final_q = r_p;
    assign o_user      = r_user;
    assign o_clamp     = r_clamp;

`ifndef SYNTHESIS
    // A convex blend of a and b can never leave [min(a,b), max(a,b)].
    function automatic logic in_span(input logic [DW-1:0] r, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b);
        return (a <= b) ? (r >= a && r <= b) : (r >= b && r <= a);
    endfunction

    logic [NCH-1:0] w_in_span;
    always_comb begin
        w_in_span = '0;
        for (int k = 0; k < NCH; k++) begin
            w_in_span[k] = in_span(blend(w_m1[k], w_m2[k]),
                                   i_lerp_1_q[k*DW +: DW], i_lerp_2_q[k*DW +: DW]);
        end
    end

    a_result_in_span: assert property (@(posedge clk) disable iff (!rst_n)
        (i_valid && o_ready) |-> (&w_in_span));
`endif

endmodule

// File: tb/tb_interp_y_pipe.sv
// Bench for interp_y_pipe: scoreboard model per instance (NCH=1/PIPE=2 and NCH=3/PIPE=3)
// plus directed beats with hand-computed results.
module tb_interp_y_pipe;

    typedef struct {
        logic [47:0] p;
        logic        u;
        logic        c;
    } exp_t;

`ifdef INTERP_Y_ROUND_EN
    localparam longint unsigned MDL_RND = 128;
    localparam logic [15:0] RND_EXP = 16'h0002;
`else
    localparam longint unsigned MDL_RND = 0;
    localparam logic [15:0] RND_EXP = 16'h0001;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance d: defaults
    logic        d_valid, d_oready, d_ovalid, d_iready, d_user, d_ouser, d_clamp;
    logic [15:0] d_a, d_b, d_wy, d_p;
    // Instance m: three channels, three stages
    logic        m_valid, m_oready, m_ovalid, m_iready, m_user, m_ouser, m_clamp;
    logic [47:0] m_a, m_b, m_p;
    logic [15:0] m_wy;

    interp_y_pipe #(.DW(16), .FRAC(8), .NCH(1), .PIPE(2), .UW(1)) u_d (
        .clk(clk), .rst_n(rst_n), .i_valid(d_valid), .o_ready(d_oready),
        .i_lerp_1_q(d_a), .i_lerp_2_q(d_b), .i_wy_q(d_wy), .i_user(d_user),
        .o_valid(d_ovalid), .i_ready(d_iready), .o_p_final_q(d_p),
        .o_user(d_ouser), .o_clamp(d_clamp)
    );

    interp_y_pipe #(.DW(16), .FRAC(8), .NCH(3), .PIPE(3), .UW(1)) u_m (
        .clk(clk), .rst_n(rst_n), .i_valid(m_valid), .o_ready(m_oready),
        .i_lerp_1_q(m_a), .i_lerp_2_q(m_b), .i_wy_q(m_wy), .i_user(m_user),
        .o_valid(m_ovalid), .i_ready(m_iready), .o_p_final_q(m_p),
        .o_user(m_ouser), .o_clamp(m_clamp)
    );

    int errors = 0;
    int checks = 0;
    int d_pops = 0;
    exp_t q_d[$];
    exp_t q_m[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference blend: clamp the weight to 1.0, mix, round (if enabled), drop 8 fraction bits.
    function automatic logic [15:0] mdl(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] wy);
        longint unsigned w, s;
        w = (wy > 16'h0100) ? 256 : longint'(wy);
        s = longint'(a) * (256 - w) + longint'(b) * w + MDL_RND;
        return 16'(s / 256);
    endfunction

    // Scoreboard for instance d
    logic        d_held;
    logic [17:0] d_snap;
    always @(negedge clk) begin
        if (!rst_n) begin
            q_d.delete();
            d_held = 1'b0;
        end else begin
            if (d_held) begin
                chk("d_stall_valid", d_ovalid, 1'b1);
                chk("d_stall_data", {d_p, d_ouser, d_clamp}, d_snap);
            end
            chk("d_oready", d_oready, !(d_ovalid && !d_iready));
            if (d_ovalid) begin
                if (q_d.size() == 0) begin
                    chk("d_spurious_valid", d_ovalid, 1'b0);
                end else begin
                    chk("d_data", d_p, q_d[0].p[15:0]);
                    chk("d_user", d_ouser, q_d[0].u);
                    chk("d_clamp", d_clamp, q_d[0].c);
                    if (d_iready) begin
                        void'(q_d.pop_front());
                        d_pops++;
                    end
                end
            end
            d_held = d_ovalid && !d_iready;
            d_snap = {d_p, d_ouser, d_clamp};
            if (d_valid && d_oready)
                q_d.push_back('{p: 48'(mdl(d_a, d_b, d_wy)), u: d_user, c: (d_wy > 16'h0100)});
        end
    end

    // Scoreboard for instance m
    logic        m_held;
    logic [49:0] m_snap;
    exp_t        m_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            q_m.delete();
            m_held = 1'b0;
        end else begin
            if (m_held) begin
                chk("m_stall_valid", m_ovalid, 1'b1);
                chk("m_stall_data", {m_p, m_ouser, m_clamp}, m_snap);
            end
            chk("m_oready", m_oready, !(m_ovalid && !m_iready));
            if (m_ovalid) begin
                if (q_m.size() == 0) begin
                    chk("m_spurious_valid", m_ovalid, 1'b0);
                end else begin
                    chk("m_data", m_p, q_m[0].p);
                    chk("m_user", m_ouser, q_m[0].u);
                    chk("m_clamp", m_clamp, q_m[0].c);
                    if (m_iready) void'(q_m.pop_front());
                end
            end
            m_held = m_ovalid && !m_iready;
            m_snap = {m_p, m_ouser, m_clamp};
            if (m_valid && m_oready) begin
                for (int k = 0; k < 3; k++)
                    m_e.p[k*16 +: 16] = mdl(m_a[k*16 +: 16], m_b[k*16 +: 16], m_wy);
                m_e.u = m_user;
                m_e.c = m_wy > 16'h0100;
                q_m.push_back(m_e);
            end
        end
    end

    // One isolated beat into d with a literal result two cycles after acceptance.
    task automatic d_send_chk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] wy,
                              input logic u, input logic [15:0] exp, input logic expc,
                              input string nm);
        @(posedge clk); #1;
        d_a = a; d_b = b; d_wy = wy; d_user = u; d_valid = 1'b1; d_iready = 1'b1;
        @(negedge clk);
        chk({nm, "_ordy"}, d_oready, 1'b1);
        @(posedge clk); #1;
        d_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_early"}, d_ovalid, 1'b0);
        @(negedge clk);
        chk({nm, "_valid"}, d_ovalid, 1'b1);
        chk({nm, "_data"}, d_p, exp);
        chk({nm, "_user"}, d_ouser, u);
        chk({nm, "_clamp"}, d_clamp, expc);
    endtask

    task automatic m_send_chk(input logic [47:0] a, input logic [47:0] b, input logic [15:0] wy,
                              input logic u, input logic [47:0] exp, input logic expc,
                              input string nm);
        @(posedge clk); #1;
        m_a = a; m_b = b; m_wy = wy; m_user = u; m_valid = 1'b1; m_iready = 1'b1;
        @(negedge clk);
        chk({nm, "_ordy"}, m_oready, 1'b1);
        @(posedge clk); #1;
        m_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk({nm, "_early"}, m_ovalid, 1'b0);
        end
        @(negedge clk);
        chk({nm, "_valid"}, m_ovalid, 1'b1);
        chk({nm, "_data"}, m_p, exp);
        chk({nm, "_user"}, m_ouser, u);
        chk({nm, "_clamp"}, m_clamp, expc);
    endtask

    task automatic d_drain(input bit rnd_ready, input string nm);
        int n;
        n = 0;
        while ((q_d.size() != 0 || d_ovalid) && n < 200) begin
            @(posedge clk); #1;
            d_iready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        d_iready = 1'b1;
        chk({nm, "_drained"}, 64'(q_d.size()), 64'd0);
    endtask

    logic [15:0] ba [6] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000, 16'h00FF, 16'h4321};
    logic [15:0] bb [6] = '{16'hABCD, 16'h0000, 16'hFFFF, 16'h8001, 16'hFF00, 16'h1234};
    logic [15:0] bw [6] = '{16'h0033, 16'h00FF, 16'h0001, 16'h0080, 16'h0200, 16'h00C0};

    initial begin
        int g;
        bit acc;
        rst_n = 1'b0;
        d_valid = 1'b0; d_a = '0; d_b = '0; d_wy = '0; d_user = 1'b0; d_iready = 1'b1;
        m_valid = 1'b0; m_a = '0; m_b = '0; m_wy = '0; m_user = 1'b0; m_iready = 1'b1;
        #3;
        chk("rst_d_valid", d_ovalid, 1'b0);
        chk("rst_d_data", d_p, 16'h0);
        chk("rst_d_user", d_ouser, 1'b0);
        chk("rst_d_clamp", d_clamp, 1'b0);
        chk("rst_d_ordy", d_oready, 1'b1);
        chk("rst_m_valid", m_ovalid, 1'b0);
        chk("rst_m_data", m_p, 48'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        d_send_chk(16'h1000, 16'h2000, 16'h0080, 1'b0, 16'h1800, 1'b0, "basic_half");
        d_send_chk(16'h1000, 16'h2000, 16'h0000, 1'b1, 16'h1000, 1'b0, "basic_w0");
        d_send_chk(16'h1000, 16'h2000, 16'h0100, 1'b0, 16'h2000, 1'b0, "basic_w1");
        d_send_chk(16'h1000, 16'h2000, 16'h0180, 1'b1, 16'h2000, 1'b1, "clamp");
        d_send_chk(16'h0001, 16'h0002, 16'h0080, 1'b0, RND_EXP, 1'b0, "round");

        m_send_chk({16'hFF00, 16'h0800, 16'h0100}, {16'h0100, 16'h0800, 16'h0300}, 16'h0040,
                   1'b1, {16'hBF80, 16'h0800, 16'h0180}, 1'b0, "mch");
        m_send_chk({16'hFF00, 16'h0800, 16'h0100}, {16'h0100, 16'h0800, 16'h0300}, 16'hFFFF,
                   1'b0, {16'h0100, 16'h0800, 16'h0300}, 1'b1, "mch_clamp");

        // Back-to-back burst: one beat per cycle, outputs handed off while inputs land
        @(posedge clk); #1;
        d_iready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_a = ba[i]; d_b = bb[i]; d_wy = bw[i]; d_user = 1'(i); d_valid = 1'b1;
            @(negedge clk);
            chk("burst_ordy", d_oready, 1'b1);
            @(posedge clk); #1;
        end
        d_valid = 1'b0;
        d_drain(1'b0, "burst");

        // Stream under random backpressure
        d_pops = 0;
        @(posedge clk); #1;
        for (int n = 1; n <= 8; n++) begin
            d_a = 16'(n); d_b = 16'(n); d_wy = 16'h0040; d_user = 1'(n); d_valid = 1'b1;
            g = 0;
            acc = 1'b0;
            while (!acc && g < 100) begin
                d_iready = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = d_oready;
                @(posedge clk); #1;
                g++;
            end
            if (!acc) chk("stream_accept_timeout", d_oready, 1'b1);
        end
        d_valid = 1'b0;
        d_drain(1'b1, "stream");
        chk("stream_count", 64'(d_pops), 64'd8);

        // Reset with two beats in flight (one held at the output)
        @(posedge clk); #1;
        d_iready = 1'b0;
        d_a = 16'h0111; d_b = 16'h0111; d_wy = 16'h0000; d_user = 1'b1; d_valid = 1'b1;
        @(posedge clk); #1;
        d_a = 16'h0222; d_b = 16'h0222;
        @(posedge clk); #1;
        d_valid = 1'b0;
        chk("rst_mid_before", d_ovalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_async_valid", d_ovalid, 1'b0);
        chk("rst_mid_async_data", d_p, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        d_iready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_stale", d_ovalid, 1'b0);
        end
        d_send_chk(16'h0400, 16'h0800, 16'h0080, 1'b1, 16'h0600, 1'b0, "post_rst");
        d_drain(1'b0, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
